tile_reader_2d: RTL
===================

// Module: tile_reader_2d
// PURPOSE
//  Parametrised 2D tile address generator and buffer reader for the router path.
//  Walks a rows x cols tile at base + r*stride + c, issues one-cycle-latency buffer reads,
//  and delivers data with its address over a valid/ready stream with backpressure.
//  Sits between the SRAM tile buffer and the router/PE-array distribution logic.
// PARAMETERS
//  DATA_WIDTH  64  buffer word width
//  ADDR_WIDTH  8   buffer address width; all address arithmetic wraps mod 2^ADDR_WIDTH
//  DIM_WIDTH   8   width of row/col count fields
//  FIFO_DEPTH  2   output skid FIFO entries (>=2); also the max outstanding-read credit
// PORTS
//  i_clk         in  1           clock
//  i_nrst        in  1           asynchronous active-low reset
//  i_start       in  1           start pulse; sampled only in IDLE
//  i_reg_clear   in  1           synchronous abort/flush, highest priority after reset
//  i_base_addr   in  ADDR_WIDTH  tile start address, latched on accepted i_start
//  i_num_rows    in  DIM_WIDTH   tile rows, latched on accepted i_start
//  i_num_cols    in  DIM_WIDTH   tile cols, latched on accepted i_start
//  i_row_stride  in  ADDR_WIDTH  address step between row starts, latched on accepted i_start
//  o_buf_read_en out 1           buffer read strobe
//  o_read_addr   out ADDR_WIDTH  buffer read address (qualified by o_buf_read_en)
//  i_buf_data    in  DATA_WIDTH  buffer data, valid the cycle after o_buf_read_en
//  o_valid       out 1           output element valid (FIFO not empty)
//  i_ready       in  1           downstream ready
//  o_data        out DATA_WIDTH  FIFO head data
//  o_data_addr   out ADDR_WIDTH  buffer address the head data came from
//  o_last        out 1           head is final element of tile
//  o_busy        out 1           state != IDLE
//  o_done        out 1           one-cycle pulse when the tile is fully delivered
// BEHAVIOUR
//  - Async reset: all outputs 0, state IDLE, FIFO empty, counters 0, no read in flight.
//  - States: IDLE -> READ -> DRAIN -> DONE -> IDLE.
//  - IDLE: accepted i_start with rows,cols != 0 -> READ; with rows==0 or cols==0 -> DONE
//    (no reads, no o_valid). i_start outside IDLE is ignored.
//  - READ: o_buf_read_en = (occupancy + inflight - pop) < FIFO_DEPTH, where pop = o_valid & i_ready.
//    Address is generated incrementally: col increments; at col==cols-1 col->0,
//    row_base += stride. Address = row_base + col, truncated to ADDR_WIDTH.
//    The read issuing the last element (row==rows-1, col==cols-1) moves the FSM to DRAIN.
//  - Data return: the cycle after o_buf_read_en, {i_buf_data, addr, last} is pushed into the FIFO.
//    The push and pop may occur in the same cycle. The credit rule guarantees no overflow.
//    Ordering is strictly preserved.
//  - Output: o_valid = FIFO non-empty. Head is held stable while o_valid & ~i_ready.
//    o_last is asserted only on the final element.
//  - DRAIN: no reads. When the last element pops, the FSM moves to DONE.
//  - DONE: o_done=1 for exactly one cycle, then IDLE. The next i_start is accepted in IDLE.
//  - Latency: i_start sampled at edge k -> o_buf_read_en high in cycle k+1, o_valid in k+2.
//  - Throughput: with i_ready held at 1, one element per cycle.
//  - i_reg_clear (any state): next cycle IDLE, FIFO flushed, in-flight return discarded,
//    o_valid=0, o_done is not pulsed. i_reg_clear wins over a simultaneous i_start.
//  - Reset mid-operation has the same effect as i_reg_clear, applied asynchronously.
// TESTING
//  - Base 0x10, 2x3, stride 8, i_ready=1 -> addrs 10,11,12,18,19,1A back-to-back.
//    o_last only on 1A. o_done one cycle after the 1A handshake.
//  - Same tile, i_ready=0 for cycles 3-8 -> at most FIFO_DEPTH reads outstanding.
//    o_data held stable. All 6 elements are delivered in order, with none lost or duplicated.
//  - i_num_rows=0 -> no o_buf_read_en, no o_valid, o_done pulse exactly once.
//  - Base 0xFE, 2x2, stride 0x10 -> addrs FE,FF,0E,0F (mod-256 wrap).
//  - 4x4 tile, i_reg_clear after 5th handshake -> o_valid and o_busy 0 next cycle, no o_done.
//    A new 1x1 start then completes normally.
//  - i_start pulsed while busy -> ignored, config unchanged.
//    i_nrst asserted mid-READ -> all outputs 0 immediately.

Source files
------------

// File: rtl/tile_reader_2d_if.sv
// tile_reader_2d_if: control, buffer-read and output-stream signals of tile_reader_2d.
//   master : the tile reader (drives o_*, samples i_*)
//   slave  : the environment (config source, tile buffer and downstream consumer)
//   control : i_start, i_reg_clear, i_base_addr, i_num_rows, i_num_cols, i_row_stride
//   buffer  : o_buf_read_en, o_read_addr, i_buf_data (one-cycle read latency)
//   stream  : o_valid, i_ready, o_data, o_data_addr, o_last
//   status  : o_busy, o_done
interface tile_reader_2d_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DIM_WIDTH  = 8
);
    logic                  i_start;
    logic                  i_reg_clear;
    logic [ADDR_WIDTH-1:0] i_base_addr;
    logic [DIM_WIDTH-1:0]  i_num_rows;
    logic [DIM_WIDTH-1:0]  i_num_cols;
    logic [ADDR_WIDTH-1:0] i_row_stride;
    logic                  o_buf_read_en;
    logic [ADDR_WIDTH-1:0] o_read_addr;
    logic [DATA_WIDTH-1:0] i_buf_data;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic [ADDR_WIDTH-1:0] o_data_addr;
    logic                  o_last;
    logic                  o_busy;
    logic                  o_done;

    modport master (
        input  i_start, i_reg_clear, i_base_addr, i_num_rows, i_num_cols, i_row_stride,
        input  i_buf_data, i_ready,
        output o_buf_read_en, o_read_addr, o_valid, o_data, o_data_addr, o_last,
        output o_busy, o_done
    );

    modport slave (
        output i_start, i_reg_clear, i_base_addr, i_num_rows, i_num_cols, i_row_stride,
        output i_buf_data, i_ready,
        input  o_buf_read_en, o_read_addr, o_valid, o_data, o_data_addr, o_last,
        input  o_busy, o_done
    );
endinterface

// File: rtl/tile_reader_2d.sv
// tile_reader_2d: walks a rows x cols tile at base + r*stride + c (mod 2^ADDR_WIDTH), issues
// one-cycle-latency buffer reads and streams {data, addr, last} out through a small skid FIFO
// with valid/ready backpressure.
//   i_clk  : clock
//   i_nrst : asynchronous active-low reset
//   bus    : tile_reader_2d_if.master (config/start/clear, buffer read port, output stream,
//            busy/done status)
module tile_reader_2d #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DIM_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic              i_clk,
    input logic              i_nrst,
    tile_reader_2d_if.master bus
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OccW = CntW + 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRead  = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [DIM_WIDTH-1:0]  rows_q, rows_d;
    logic [DIM_WIDTH-1:0]  cols_q, cols_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [DIM_WIDTH-1:0]  row_q, row_d;
    logic [DIM_WIDTH-1:0]  col_q, col_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;

    // Read issued last cycle; its data is on i_buf_data this cycle.
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_addr_q, inflight_addr_d;
    logic                  inflight_last_q, inflight_last_d;

    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;

    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic                  fifo_last_q [FIFO_DEPTH];

    logic                  valid;
    logic                  pop;
    logic                  push;
    logic                  read_en;
    logic                  last_elem;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [OccW-1:0]       committed;

    always_comb begin
        valid     = (count_q != '0);
        pop       = valid & bus.i_ready;
        push      = inflight_q & ~bus.i_reg_clear;
        cur_addr  = row_base_q + ADDR_WIDTH'(col_q);
        last_elem = (row_q == rows_q - DIM_WIDTH'(1)) && (col_q == cols_q - DIM_WIDTH'(1));
        // Entries held plus the read already in flight, less the one leaving this cycle:
        // a new read is only issued if its data is guaranteed a FIFO slot.
        committed = OccW'(count_q) + OccW'(inflight_q) - OccW'(pop);
        read_en   = (state_q == StRead) && (committed < OccW'(FIFO_DEPTH));
    end

    always_comb begin
        state_d         = state_q;
        rows_d          = rows_q;
        cols_d          = cols_q;
        stride_d        = stride_q;
        row_d           = row_q;
        col_d           = col_q;
        row_base_d      = row_base_q;
        inflight_d      = read_en;
        inflight_addr_d = cur_addr;
        inflight_last_d = last_elem;

        case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    rows_d     = bus.i_num_rows;
                    cols_d     = bus.i_num_cols;
                    stride_d   = bus.i_row_stride;
                    row_base_d = bus.i_base_addr;
                    row_d      = '0;
                    col_d      = '0;
                    if (bus.i_num_rows == '0 || bus.i_num_cols == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                if (read_en) begin
                    if (col_q == cols_q - DIM_WIDTH'(1)) begin
                        col_d      = '0;
                        row_d      = row_q + DIM_WIDTH'(1);
                        row_base_d = row_base_q + stride_q;
                        if (row_q == rows_q - DIM_WIDTH'(1)) begin
                            state_d = StDrain;
                        end
                    end else begin
                        col_d = col_q + DIM_WIDTH'(1);
                    end
                end
            end
            StDrain: begin
                if (pop && fifo_last_q[rd_ptr_q]) begin
                    state_d = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (bus.i_reg_clear) begin
            state_d    = StIdle;
            inflight_d = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CntW'(push) - CntW'(pop);
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        if (bus.i_reg_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q         <= StIdle;
            rows_q          <= '0;
            cols_q          <= '0;
            stride_q        <= '0;
            row_q           <= '0;
            col_q           <= '0;
            row_base_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            inflight_last_q <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            rows_q          <= rows_d;
            cols_q          <= cols_d;
            stride_q        <= stride_d;
            row_q           <= row_d;
            col_q           <= col_d;
            row_base_q      <= row_base_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            inflight_last_q <= inflight_last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
        end
    end

    // FIFO storage is never observed while empty (outputs are gated by valid), so no reset.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= bus.i_buf_data;
            fifo_addr_q[wr_ptr_q] <= inflight_addr_q;
            fifo_last_q[wr_ptr_q] <= inflight_last_q;
        end
    end

    always_comb begin
        bus.o_buf_read_en = read_en;
        bus.o_read_addr   = read_en ? cur_addr : '0;
        bus.o_valid       = valid;
        bus.o_data        = valid ? fifo_data_q[rd_ptr_q] : '0;
        bus.o_data_addr   = valid ? fifo_addr_q[rd_ptr_q] : '0;
        bus.o_last        = valid ? fifo_last_q[rd_ptr_q] : 1'b0;
        bus.o_busy        = (state_q != StIdle);
        bus.o_done        = (state_q == StDone);
    end
endmodule
